// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, control-flow op types and PSR flag bit positions.
// The ALU and the PSR register use the same PSR indices.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_HI = 4'h4;
   localparam logic [3:0] COND_LS = 4'h5;
   localparam logic [3:0] COND_GT = 4'h6;
   localparam logic [3:0] COND_LE = 4'h7;
   localparam logic [3:0] COND_FS = 4'h8;
   localparam logic [3:0] COND_FC = 4'h9;
   localparam logic [3:0] COND_LO = 4'hA;
   localparam logic [3:0] COND_HS = 4'hB;
   localparam logic [3:0] COND_LT = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_UC = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam logic [1:0] OPT_BCOND = 2'b00;
   localparam logic [1:0] OPT_JCOND = 2'b01;
   localparam logic [1:0] OPT_JAL   = 2'b10;

   localparam int unsigned PSR_C = 4;
   localparam int unsigned PSR_F = 3;
   localparam int unsigned PSR_L = 2;
   localparam int unsigned PSR_Z = 1;
   localparam int unsigned PSR_N = 0;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit condition and the
// current PSR flags to a taken/not-taken decision.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] psr_flags,
   output logic       taken_cond
);

   logic f_c, f_f, f_l, f_z, f_n;

   always_comb begin
      f_c = psr_flags[PSR_C];
      f_f = psr_flags[PSR_F];
      f_l = psr_flags[PSR_L];
      f_z = psr_flags[PSR_Z];
      f_n = psr_flags[PSR_N];
      taken_cond = 1'b0;
      case (cond)
         COND_EQ: taken_cond = f_z;
         COND_NE: taken_cond = !f_z;
         COND_CS: taken_cond = f_c;
         COND_CC: taken_cond = !f_c;
         COND_HI: taken_cond = f_l;
         COND_LS: taken_cond = !f_l;
         COND_GT: taken_cond = f_n;
         COND_LE: taken_cond = !f_n;
         COND_FS: taken_cond = f_f;
         COND_FC: taken_cond = !f_f;
         COND_LO: taken_cond = !f_l && !f_z;
         COND_HS: taken_cond = f_l || f_z;
         COND_LT: taken_cond = !f_n && !f_z;
         COND_GE: taken_cond = f_n || f_z;
         COND_UC: taken_cond = 1'b1;
         default: taken_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates control-flow ops against the PSR,
// drives the fetch PC, squashes younger fetches and counts taken branches.
module branch_resolve_unit
   import cpu_pkg::*;
#(
   parameter int unsigned         ADDR_W       = 16,
   parameter logic [ADDR_W-1:0]   RESET_PC     = '0,
   parameter int unsigned         FLUSH_CYCLES = 2,
   parameter int unsigned         CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [4:0]        psr_flags,
   input  logic              op_valid,
   input  logic [1:0]        op_type,
   input  logic [3:0]        cond,
   input  logic [7:0]        disp,
   input  logic [ADDR_W-1:0] target,
   input  logic [ADDR_W-1:0] op_pc,
   output logic [ADDR_W-1:0] pc,
   output logic              redirect,
   output logic              flush,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data,
   output logic [CNT_W-1:0]  taken_count
);

   localparam int unsigned CNT_FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_FW-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              redirect_q, redirect_d;
   logic              flush_q, flush_d;
   logic              link_we_q, link_we_d;
   logic [ADDR_W-1:0] link_data_q, link_data_d;
   logic [CNT_W-1:0]  taken_count_q, taken_count_d;

   logic              cond_true;
   logic              op_taken;
   logic [ADDR_W-1:0] branch_tgt;

   cond_eval u_cond_eval (
      .cond       (cond),
      .psr_flags  (psr_flags),
      .taken_cond (cond_true)
   );

   always_comb begin
      op_taken   = 1'b0;
      branch_tgt = target;
      case (op_type)
         OPT_BCOND: begin
            op_taken   = cond_true;
            branch_tgt = op_pc + ADDR_W'($signed(disp));
         end
         OPT_JCOND: op_taken = cond_true;
         OPT_JAL:   op_taken = 1'b1;
         default:   op_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_d          = pc_q;
      redirect_d    = 1'b0;
      flush_d       = flush_q;
      link_we_d     = 1'b0;
      link_data_d   = link_data_q;
      taken_count_d = taken_count_q;
      if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (op_valid && op_taken) begin
                  pc_d       = branch_tgt;
                  redirect_d = 1'b1;
                  flush_d    = 1'b1;
                  cnt_d      = CNT_FW'(FLUSH_CYCLES - 1);
                  state_d    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                  if (taken_count_q != '1) taken_count_d = taken_count_q + CNT_W'(1);
                  if (op_type == OPT_JAL) begin
                     link_we_d   = 1'b1;
                     link_data_d = op_pc + ADDR_W'(1);
                  end
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  flush_d = 1'b0;
               end
            end
            ST_FLUSH: begin
               // Ops arriving inside the window are younger than the redirect and are dropped.
               pc_d    = pc_q + ADDR_W'(1);
               flush_d = 1'b1;
               cnt_d   = cnt_q - CNT_FW'(1);
               if (cnt_q == CNT_FW'(1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         pc_q          <= RESET_PC;
         redirect_q    <= 1'b0;
         flush_q       <= 1'b0;
         link_we_q     <= 1'b0;
         link_data_q   <= '0;
         taken_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pc_q          <= pc_d;
         redirect_q    <= redirect_d;
         flush_q       <= flush_d;
         link_we_q     <= link_we_d;
         link_data_q   <= link_data_d;
         taken_count_q <= taken_count_d;
      end
   end

   assign pc          = pc_q;
   assign redirect    = redirect_q;
   assign flush       = flush_q;
   assign link_we     = link_we_q;
   assign link_data   = link_data_q;
   assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural model.
module tb_branch_resolve_unit;

   localparam int ADDR_W       = 16;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 16;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, stall, op_valid;
   logic [4:0]        psr_flags;
   logic [1:0]        op_type;
   logic [3:0]        cond;
   logic [7:0]        disp;
   logic [ADDR_W-1:0] target, op_pc;

   logic [ADDR_W-1:0] pc, link_data;
   logic              redirect, flush, link_we;
   logic [CNT_W-1:0]  taken_count;

   logic [ADDR_W-1:0] s_pc, s_link_data;
   logic              s_redirect, s_flush, s_link_we;
   logic [1:0]        s_taken_count;

   int checks = 0;
   int errors = 0;

   // model state
   logic [ADDR_W-1:0] m_pc, m_link_data;
   logic              m_redirect, m_link_we;
   int                m_flush_left, m_count;

   branch_resolve_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .psr_flags(psr_flags), .op_valid(op_valid),
      .op_type(op_type), .cond(cond), .disp(disp), .target(target), .op_pc(op_pc),
      .pc(pc), .redirect(redirect), .flush(flush), .link_we(link_we),
      .link_data(link_data), .taken_count(taken_count)
   );

   // single-cycle flush window and tiny counter to reach saturation quickly
   branch_resolve_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .FLUSH_CYCLES(1), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .stall(stall), .psr_flags(psr_flags), .op_valid(op_valid),
      .op_type(op_type), .cond(cond), .disp(disp), .target(target), .op_pc(op_pc),
      .pc(s_pc), .redirect(s_redirect), .flush(s_flush), .link_we(s_link_we),
      .link_data(s_link_data), .taken_count(s_taken_count)
   );

   function automatic bit ref_cond(input logic [3:0] cc, input logic [4:0] f);
      bit fc, ff, fl, fz, fn;
      fc = f[4]; ff = f[3]; fl = f[2]; fz = f[1]; fn = f[0];
      case (cc)
         4'h0: return fz;         4'h1: return !fz;
         4'h2: return fc;         4'h3: return !fc;
         4'h4: return fl;         4'h5: return !fl;
         4'h6: return fn;         4'h7: return !fn;
         4'h8: return ff;         4'h9: return !ff;
         4'hA: return !fl && !fz; 4'hB: return fl || fz;
         4'hC: return !fn && !fz; 4'hD: return fn || fz;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_edge();
      bit taken;
      int t;
      m_redirect = 1'b0;
      m_link_we  = 1'b0;
      if (reset) begin
         m_pc = '0; m_flush_left = 0; m_link_data = '0; m_count = 0;
         return;
      end
      if (stall) return;
      if (m_flush_left > 1) begin
         m_pc = m_pc + 16'd1;
         m_flush_left = m_flush_left - 1;
         return;
      end
      taken = op_valid && (op_type == 2'd2 || (op_type < 2'd2 && ref_cond(cond, psr_flags)));
      if (taken) begin
         if (op_type == 2'd0) begin
            t = int'(op_pc) + ((disp >= 8'd128) ? int'(disp) - 256 : int'(disp));
            m_pc = t[15:0];
         end else begin
            m_pc = target;
         end
         m_redirect   = 1'b1;
         m_flush_left = FLUSH_CYCLES;
         if (m_count < CNT_MAX) m_count = m_count + 1;
         if (op_type == 2'd2) begin
            m_link_we   = 1'b1;
            m_link_data = op_pc + 16'd1;
         end
      end else begin
         m_pc = m_pc + 16'd1;
         m_flush_left = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic present(input logic [1:0] ty, input logic [3:0] cc, input logic [7:0] d,
                          input logic [15:0] tg, input logic [15:0] opc);
      op_valid = 1'b1; op_type = ty; cond = cc; disp = d; target = tg; op_pc = opc;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; op_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({pc, redirect, flush, link_we, link_data, taken_count} !== '0) begin
         errors++;
         $display("FAIL reset_state got pc=%h rd=%b fl=%b lw=%b ld=%h cnt=%0d want all zero",
                  pc, redirect, flush, link_we, link_data, taken_count);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (pc !== 16'(i) || flush !== 1'b0 || taken_count !== '0) begin
            errors++;
            $display("FAIL idle_pc got pc=%h fl=%b cnt=%0d want pc=%h fl=0 cnt=0", pc, flush, taken_count, 16'(i));
         end
      end
   endtask

   task automatic test_bcond_taken();
      psr_flags = 5'b00010;
      present(2'b00, 4'h0, 8'hFC, 16'h0000, 16'h0010);
      tick();
      op_valid = 1'b0;
      checks++;
      if (pc !== 16'h000C || redirect !== 1'b1 || flush !== 1'b1 || taken_count !== 16'd1) begin
         errors++;
         $display("FAIL bcond_taken got pc=%h rd=%b fl=%b cnt=%0d want pc=000c rd=1 fl=1 cnt=1",
                  pc, redirect, flush, taken_count);
      end
      tick();
      checks++;
      if (pc !== 16'h000D || redirect !== 1'b0 || flush !== 1'b1) begin
         errors++;
         $display("FAIL bcond_flush2 got pc=%h rd=%b fl=%b want pc=000d rd=0 fl=1", pc, redirect, flush);
      end
      tick();
      checks++;
      if (pc !== 16'h000E || flush !== 1'b0) begin
         errors++;
         $display("FAIL bcond_flush_end got pc=%h fl=%b want pc=000e fl=0", pc, flush);
      end
   endtask

   task automatic test_bcond_not_taken();
      logic [15:0] prev;
      psr_flags = 5'b00000;
      prev = pc;
      present(2'b00, 4'h0, 8'hFC, 16'h0000, 16'h0010);
      tick();
      op_valid = 1'b0;
      checks++;
      if (pc !== prev + 16'd1 || redirect !== 1'b0 || flush !== 1'b0 || taken_count !== 16'd1) begin
         errors++;
         $display("FAIL bcond_not_taken got pc=%h rd=%b fl=%b cnt=%0d want pc=%h rd=0 fl=0 cnt=1",
                  pc, redirect, flush, taken_count, prev + 16'd1);
      end
   endtask

   task automatic test_jal();
      present(2'b10, 4'hF, 8'h00, 16'h1234, 16'h0050);
      tick();
      checks++;
      if (pc !== 16'h1234 || redirect !== 1'b1 || link_we !== 1'b1 || link_data !== 16'h0051 || taken_count !== 16'd2) begin
         errors++;
         $display("FAIL jal got pc=%h rd=%b lw=%b ld=%h cnt=%0d want pc=1234 rd=1 lw=1 ld=0051 cnt=2",
                  pc, redirect, link_we, link_data, taken_count);
      end
      present(2'b10, 4'hE, 8'h00, 16'h4000, 16'h0060);
      tick();
      op_valid = 1'b0;
      checks++;
      if (pc !== 16'h1235 || redirect !== 1'b0 || link_we !== 1'b0 || link_data !== 16'h0051 || taken_count !== 16'd2) begin
         errors++;
         $display("FAIL jal_in_flush_ignored got pc=%h rd=%b lw=%b ld=%h cnt=%0d want pc=1235 rd=0 lw=0 ld=0051 cnt=2",
                  pc, redirect, link_we, link_data, taken_count);
      end
      tick();
   endtask

   task automatic test_cond_sweep();
      logic [15:0] prev, tg;
      bit exp;
      for (int cc = 0; cc < 16; cc++) begin
         for (int f = 0; f < 32; f++) begin
            while (m_flush_left > 1) tick();
            prev = pc;
            tg = 16'h8000 | 16'(cc << 8) | 16'(f);
            psr_flags = 5'(f);
            present(2'b01, 4'(cc), 8'h00, tg, 16'h0000);
            exp = ref_cond(4'(cc), 5'(f));
            tick();
            op_valid = 1'b0;
            checks++;
            if (redirect !== exp || pc !== (exp ? tg : prev + 16'd1)) begin
               errors++;
               $display("FAIL cond_sweep cond=%h flags=%b got rd=%b pc=%h want rd=%b pc=%h",
                        cc[3:0], f[4:0], redirect, pc, exp, exp ? tg : prev + 16'd1);
            end
         end
      end
      while (m_flush_left > 0) tick();
   endtask

   task automatic test_stall();
      psr_flags = 5'b00000;
      present(2'b01, 4'hE, 8'h00, 16'h2000, 16'h0000);
      tick();
      op_valid = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (pc !== 16'h2000 || flush !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got pc=%h fl=%b rd=%b want pc=2000 fl=1 rd=0", pc, flush, redirect);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (pc !== 16'h2001 || flush !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume got pc=%h fl=%b want pc=2001 fl=1", pc, flush);
      end
      tick();
      checks++;
      if (pc !== 16'h2002 || flush !== 1'b0) begin
         errors++;
         $display("FAIL stall_flush_end got pc=%h fl=%b want pc=2002 fl=0", pc, flush);
      end
   endtask

   task automatic test_reset_mid_flush();
      present(2'b01, 4'hE, 8'h00, 16'h3000, 16'h0000);
      tick();
      op_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (pc !== 16'h0000 || flush !== 1'b0 || redirect !== 1'b0 || taken_count !== '0) begin
         errors++;
         $display("FAIL reset_mid_flush got pc=%h fl=%b rd=%b cnt=%0d want pc=0000 fl=0 rd=0 cnt=0",
                  pc, flush, redirect, taken_count);
      end
      tick();
      checks++;
      if (pc !== 16'h0001 || flush !== 1'b0) begin
         errors++;
         $display("FAIL after_reset got pc=%h fl=%b want pc=0001 fl=0", pc, flush);
      end
   endtask

   task automatic test_wrap();
      present(2'b01, 4'hE, 8'h00, 16'hFFFF, 16'h0000);
      tick();
      op_valid = 1'b0;
      tick();
      checks++;
      if (pc !== 16'h0000 || flush !== 1'b1) begin
         errors++;
         $display("FAIL pc_wrap got pc=%h fl=%b want pc=0000 fl=1", pc, flush);
      end
      tick();
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         present(2'b01, 4'hE, 8'h00, 16'(16'h0100 * i), 16'h0000);
         tick();
         checks++;
         if (s_redirect !== 1'b1 || s_flush !== 1'b1 || s_taken_count !== 2'((i > 3) ? 3 : i)) begin
            errors++;
            $display("FAIL sat_back_to_back i=%0d got rd=%b fl=%b cnt=%0d want rd=1 fl=1 cnt=%0d",
                     i, s_redirect, s_flush, s_taken_count, (i > 3) ? 3 : i);
         end
      end
      op_valid = 1'b0;
      tick();
      checks++;
      if (s_flush !== 1'b0 || s_taken_count !== 2'd3) begin
         errors++;
         $display("FAIL sat_hold got fl=%b cnt=%0d want fl=0 cnt=3", s_flush, s_taken_count);
      end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] exp_cnt;
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(63) == 0);
         stall     = ($urandom_range(7) == 0);
         op_valid  = $urandom_range(1);
         op_type   = 2'($urandom_range(3));
         cond      = 4'($urandom_range(15));
         disp      = 8'($urandom);
         target    = 16'($urandom);
         op_pc     = 16'($urandom);
         psr_flags = 5'($urandom);
         tick();
         exp_cnt = 16'(m_count);
         checks++;
         if ({pc, redirect, flush, link_we, link_data, taken_count} !==
             {m_pc, m_redirect, (m_flush_left > 0), m_link_we, m_link_data, exp_cnt}) begin
            errors++;
            $display("FAIL random cyc=%0d got pc=%h rd=%b fl=%b lw=%b ld=%h cnt=%0d want pc=%h rd=%b fl=%b lw=%b ld=%h cnt=%0d",
                     i, pc, redirect, flush, link_we, link_data, taken_count,
                     m_pc, m_redirect, (m_flush_left > 0), m_link_we, m_link_data, exp_cnt);
         end
      end
      reset = 1'b0; stall = 1'b0; op_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; op_valid = 1'b0; psr_flags = '0;
      op_type = '0; cond = '0; disp = '0; target = '0; op_pc = '0;
      m_pc = '0; m_link_data = '0; m_redirect = 1'b0; m_link_we = 1'b0;
      m_flush_left = 0; m_count = 0;
      test_reset();
      test_bcond_taken();
      test_bcond_not_taken();
      test_jal();
      test_cond_sweep();
      test_stall();
      test_reset_mid_flush();
      test_wrap();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
